// File: rtl/rr_mux_reg.sv
// Registered N-channel multiplexer with valid/ready handshakes, round-robin
// arbitration and a forced-select mode that mimics plain mux steering.
module rr_mux_reg #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned SEL_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [CHANNELS-1:0]           in_valid,
  output logic [CHANNELS-1:0]           in_ready,
  input  logic [CHANNELS*BIT_WIDTH-1:0] in_data,
  input  logic                          force_en,
  input  logic [SEL_WIDTH-1:0]          force_sel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIT_WIDTH-1:0]          out_data,
  output logic [SEL_WIDTH-1:0]          out_channel
);

  localparam int unsigned          SLOTS   = 1 << SEL_WIDTH;
  localparam logic [SEL_WIDTH:0]   CH_EXT  = (SEL_WIDTH+1)'(CHANNELS);
  localparam logic [SEL_WIDTH-1:0] LAST_CH = SEL_WIDTH'(CHANNELS - 1);

  logic                 out_valid_q, out_valid_d;
  logic [BIT_WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_WIDTH-1:0] out_chan_q,  out_chan_d;
  logic [SEL_WIDTH-1:0] ptr_q,       ptr_d;

  logic [SLOTS-1:0]     valid_pad;
  logic [SLOTS-1:0]     ready_pad;
  logic [BIT_WIDTH-1:0] data_slot [SLOTS];

  logic                 grant_vld;
  logic [SEL_WIDTH-1:0] grant_idx;
  logic [SEL_WIDTH-1:0] fsel;
  logic [SEL_WIDTH:0]   cand;
  logic                 load_ok;
  logic                 xfer_in;

  // Channel vectors are padded to the full index range so that any
  // SEL_WIDTH-bit index is in bounds; unused slots read as idle/zero.
  assign valid_pad = SLOTS'(in_valid);

  for (genvar c = 0; c < SLOTS; c++) begin : g_slot
    if (c < CHANNELS) begin : g_real
      assign data_slot[c] = in_data[c*BIT_WIDTH +: BIT_WIDTH];
    end else begin : g_pad
      assign data_slot[c] = '0;
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    fsel      = '0;
    cand      = '0;
    if (force_en) begin
      fsel      = ({1'b0, force_sel} < CH_EXT) ? force_sel : '0;
      grant_vld = valid_pad[fsel];
      grant_idx = fsel;
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        cand = {1'b0, ptr_q} + (SEL_WIDTH+1)'(k);
        if (cand >= CH_EXT) begin
          cand = cand - CH_EXT;
        end
        if (!grant_vld && valid_pad[cand[SEL_WIDTH-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand[SEL_WIDTH-1:0];
        end
      end
    end
  end

  assign load_ok = !out_valid_q || out_ready;
  assign xfer_in = grant_vld && load_ok;

  always_comb begin
    ready_pad = '0;
    if (grant_vld) begin
      ready_pad[grant_idx] = load_ok;
    end
  end

  assign in_ready = ready_pad[CHANNELS-1:0];

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer_in) begin
      out_valid_d = 1'b1;
      out_data_d  = data_slot[grant_idx];
      out_chan_d  = grant_idx;
      if (!force_en) begin
        ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + SEL_WIDTH'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_channel = out_chan_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg (4 channels): expected words are queued when
// accepted and compared while held and when drained.
module tb_rr_mux_reg;

  localparam int unsigned BW = 32;
  localparam int unsigned CH = 4;
  localparam int unsigned SW = 3;

  typedef struct packed {
    logic [SW-1:0] ch;
    logic [BW-1:0] data;
  } word_t;

  logic              clk;
  logic              reset_n;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready;
  logic [CH*BW-1:0]  in_data;
  logic              force_en;
  logic [SW-1:0]     force_sel;
  logic              out_valid;
  logic              out_ready;
  logic [BW-1:0]     out_data;
  logic [SW-1:0]     out_channel;

  int    n_vec = 0;
  int    n_err = 0;
  int    tag   = 1;
  word_t q[$];

  rr_mux_reg #(
    .BIT_WIDTH(BW),
    .CHANNELS (CH),
    .SEL_WIDTH(SW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .force_en   (force_en),
    .force_sel  (force_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_channel(out_channel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [BW-1:0] data_of(input int ch);
    logic [23:0] t;
    t = tag[23:0];
    return {t, 8'(8'h10 + ch)};
  endfunction

  task automatic drive_data();
    for (int i = 0; i < int'(CH); i++) in_data[i*BW +: BW] = data_of(i);
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
    end
  endtask

  // One clock: drive inputs, check held word and in_ready, model the edge.
  task automatic step(input logic [3:0] v, input logic ordy, input logic fen,
                      input logic [2:0] fsel, input logic [3:0] exp_rdy, input int exp_ch);
    word_t w;
    in_valid = v; out_ready = ordy; force_en = fen; force_sel = fsel;
    drive_data();
    #1;
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_channel", 64'(out_channel), 64'(q[0].ch));
      chk("out_data", 64'(out_data), 64'(q[0].data));
    end
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (q.size() != 0 && ordy) void'(q.pop_front());
    if (exp_ch >= 0) begin
      w.ch = SW'(exp_ch);
      w.data = data_of(exp_ch);
      q.push_back(w);
    end
    @(posedge clk); #1;
    tag++;
  endtask

  task automatic do_reset(input logic [3:0] v, input logic ordy, input logic [3:0] exp_rdy);
    reset_n = 1'b0; in_valid = v; out_ready = ordy; force_en = 1'b0; force_sel = '0;
    drive_data();
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk); #1;
    q.delete();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_channel", 64'(out_channel), 64'(0));
    reset_n = 1'b1;
    tag++;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = '1; out_ready = 1'b0; force_en = 1'b0; force_sel = '0;
    drive_data();
    @(posedge clk); #1;
    do_reset(4'b1111, 1'b1, 4'b0001);

    // round-robin fairness, all channels requesting
    step(4'b1111, 1, 0, 0, 4'b0001, 0);
    step(4'b1111, 1, 0, 0, 4'b0010, 1);
    step(4'b1111, 1, 0, 0, 4'b0100, 2);
    step(4'b1111, 1, 0, 0, 4'b1000, 3);
    step(4'b1111, 1, 0, 0, 4'b0001, 0);
    step(4'b1111, 1, 0, 0, 4'b0010, 1);
    // bring ptr to 3, then wrap and skip
    step(4'b0100, 1, 0, 0, 4'b0100, 2);
    step(4'b0101, 1, 0, 0, 4'b0001, 0);
    step(4'b0101, 1, 0, 0, 4'b0100, 2);
    step(4'b0101, 1, 0, 0, 4'b0001, 0);
    // backpressure for 5 cycles, data inputs change every cycle
    for (int i = 0; i < 5; i++) step(4'b1111, 0, 0, 0, 4'b0000, -1);
    step(4'b1111, 1, 0, 0, 4'b0010, 1);
    // forced mode, ptr (now 2) must hold
    step(4'b1111, 1, 1, 2, 4'b0100, 2);
    step(4'b1111, 1, 1, 2, 4'b0100, 2);
    step(4'b1111, 1, 1, 2, 4'b0100, 2);
    step(4'b1111, 1, 1, 7, 4'b0001, 0);
    step(4'b1111, 1, 1, 7, 4'b0001, 0);
    step(4'b1111, 1, 1, 3, 4'b1000, 3);
    step(4'b1111, 1, 0, 0, 4'b0100, 2);
    // drain, then single requester after idle
    step(4'b0000, 1, 0, 0, 4'b0000, -1);
    step(4'b0010, 1, 0, 0, 4'b0010, 1);
    step(4'b0000, 0, 0, 0, 4'b0000, -1);
    // reset while a word is pending
    do_reset(4'b1111, 1'b0, 4'b0000);
    step(4'b1111, 0, 0, 0, 4'b0001, 0);
    step(4'b1111, 1, 0, 0, 4'b0010, 1);
    step(4'b0000, 1, 0, 0, 4'b0000, -1);
    step(4'b0000, 1, 0, 0, 4'b0000, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
